// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: delay line, coefficient file and one shared MAC step per tap.
// Optional per-step saturation of the accumulator is enabled by defining FIR_SAT_EN.
module fir_mac_sequencer #(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int TAPS = 4,
    parameter int AW   = 2,
    parameter int ACCW = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_data,
    input  logic                   coef_we,
    input  logic [AW-1:0]          coef_addr,
    input  logic signed [CW-1:0]   coef_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [ACCW-1:0] out_data,
    output logic                   busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [AW-1:0]          k_q, k_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] out_data_q, out_data_d;
    logic                   in_ready_q, out_valid_q, busy_q;
    logic signed [DW-1:0]   dline_q [TAPS];
    logic signed [CW-1:0]   coef_q  [TAPS];

    logic [AW:0]            rd_sum_s;
    logic [AW-1:0]          rd_addr_s;
    logic signed [DW+CW-1:0] prod_s;
    logic signed [ACCW-1:0] prod_ext_s;
    logic signed [ACCW-1:0] acc_next_s;
    logic                   last_tap_s;

    // Delay-line read address (wr_ptr - k) mod TAPS, valid for non-power-of-two TAPS too.
    always_comb begin
        rd_sum_s = {1'b0, wr_ptr_q} + (AW+1)'(TAPS) - {1'b0, k_q};
        if (rd_sum_s >= (AW+1)'(TAPS)) begin
            rd_addr_s = AW'(rd_sum_s - (AW+1)'(TAPS));
        end else begin
            rd_addr_s = AW'(rd_sum_s);
        end
    end

    assign prod_s     = dline_q[rd_addr_s] * coef_q[k_q];
    assign prod_ext_s = ACCW'(prod_s);
    assign last_tap_s = (k_q == AW'(TAPS - 1));

`ifdef FIR_SAT_EN
    logic signed [ACCW:0] sum_wide_s;

    // Clamp each accumulate step when the extra sign bit disagrees with the result MSB.
    always_comb begin
        sum_wide_s = {acc_q[ACCW-1], acc_q} + {prod_ext_s[ACCW-1], prod_ext_s};
        if (sum_wide_s[ACCW] != sum_wide_s[ACCW-1]) begin
            if (sum_wide_s[ACCW]) begin
                acc_next_s = {1'b1, {(ACCW-1){1'b0}}};
            end else begin
                acc_next_s = {1'b0, {(ACCW-1){1'b1}}};
            end
        end else begin
            acc_next_s = sum_wide_s[ACCW-1:0];
        end
    end
`else
    assign acc_next_s = acc_q + prod_ext_s;
`endif

    // Sequencer next-state logic.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wr_ptr_d   = wr_ptr_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    acc_d   = {ACCW{1'b0}};
                    k_d     = {AW{1'b0}};
                    state_d = S_MAC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                acc_d = acc_next_s;
                if (last_tap_s) begin
                    out_data_d = acc_next_s;
                    wr_ptr_d   = (wr_ptr_q == AW'(TAPS - 1)) ? {AW{1'b0}} : wr_ptr_q + AW'(1);
                    state_d    = S_DONE;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and storage registers; outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= {AW{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            acc_q       <= {ACCW{1'b0}};
            out_data_q  <= {ACCW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                dline_q[i] <= {DW{1'b0}};
                coef_q[i]  <= {CW{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_ptr_q    <= wr_ptr_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
            if ((state_q == S_IDLE) && in_valid) begin
                dline_q[wr_ptr_q] <= in_data;
            end
            if (coef_we && (state_q != S_MAC)) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
endmodule
